// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register and a one-entry skid buffer.
// Optional performance counters are enabled by defining IF_PERF_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  // state | meaning
  // BOOT  | first cycle after reset, no request
  // FETCH | request at pc outstanding
  // SKID  | fetched word parked while ID is stalled
  // DRAIN | waiting out a request orphaned by a redirect
  typedef enum logic [1:0] {BOOT, FETCH, SKID, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drain_addr, drain_addr_nxt;
  logic [31:0] skid_instr, skid_instr_nxt;
  logic [31:0] skid_pc4, skid_pc4_nxt;
  logic [31:0] instr_nxt, pc4_nxt;
  logic        valid_nxt;
  logic [31:0] pc_inc, target;

  assign pc_inc    = pc + 32'd4;
  assign target    = {redirect_pc[31:2], 2'b00};
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      drain_addr  <= RESET_PC;
      skid_instr  <= 32'h0;
      skid_pc4    <= 32'h0;
      instruction <= 32'h0;
      pc_plus4    <= 32'h0;
      if_valid    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drain_addr  <= drain_addr_nxt;
      skid_instr  <= skid_instr_nxt;
      skid_pc4    <= skid_pc4_nxt;
      instruction <= instr_nxt;
      pc_plus4    <= pc4_nxt;
      if_valid    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drain_addr_nxt = drain_addr;
    skid_instr_nxt = skid_instr;
    skid_pc4_nxt   = skid_pc4;
    instr_nxt      = instruction;
    pc4_nxt        = pc_plus4;
    valid_nxt      = if_valid;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (redirect) begin
          instr_nxt = 32'h0;
          pc4_nxt   = 32'h0;
          valid_nxt = 1'b0;
          pc_nxt    = target;
          // An unacked request cannot be withdrawn; wait it out in DRAIN.
          if (!imem_ack) begin
            drain_addr_nxt = pc;
            state_nxt      = DRAIN;
          end
        end else if (imem_ack && !stall) begin
          instr_nxt = imem_rdata;
          pc4_nxt   = pc_inc;
          valid_nxt = 1'b1;
          pc_nxt    = pc_inc;
        end else if (imem_ack) begin
          skid_instr_nxt = imem_rdata;
          skid_pc4_nxt   = pc_inc;
          pc_nxt         = pc_inc;
          state_nxt      = SKID;
        end else if (!stall) begin
          instr_nxt = 32'h0;
          pc4_nxt   = 32'h0;
          valid_nxt = 1'b0;
        end
      end
      SKID: begin
        if (redirect) begin
          instr_nxt = 32'h0;
          pc4_nxt   = 32'h0;
          valid_nxt = 1'b0;
          pc_nxt    = target;
          state_nxt = FETCH;
        end else if (!stall) begin
          instr_nxt = skid_instr;
          pc4_nxt   = skid_pc4;
          valid_nxt = 1'b1;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        instr_nxt = 32'h0;
        pc4_nxt   = 32'h0;
        valid_nxt = 1'b0;
        if (redirect) begin
          pc_nxt = target;
        end else if (imem_ack) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

`ifdef IF_PERF_EN
  logic        load_valid;
  logic [31:0] fetch_q, bubble_q;

  assign load_valid = !redirect && !stall &&
                      (((state == FETCH) && imem_ack) || (state == SKID));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_q  <= 32'h0;
      bubble_q <= 32'h0;
    end else begin
      if (load_valid) fetch_q <= fetch_q + 32'd1;
      if ((state != BOOT) && !if_valid) bubble_q <= bubble_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_q;
  assign bubble_count = bubble_q;
`else
  assign fetch_count  = 32'h0;
  assign bubble_count = 32'h0;
`endif

endmodule
